uart_cmd_parser: RTL

Byte-level command framer on the user side of the UART. It consumes received bytes (`received`/`rx_byte`/`recv_error`), assembles checksummed command frames from the host, and presents each valid frame to the vehicle control logic as a one-cycle command strobe. It returns a single ACK or NAK byte through the UART transmit handshake (`transmit`/`tx_byte`/`is_transmitting`).

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/uart_cmd_timeout.sv | 48 ++++
 rtl/uart_cmd_parser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module   : uart_cmd_pkg
// Summary  : Shared state encoding, default framing bytes and width helper
//            for the UART command parser.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_ID      = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  localparam logic [7:0] C_DEF_SYNC = 8'hAA;
  localparam logic [7:0] C_DEF_ACK  = 8'h06;
  localparam logic [7:0] C_DEF_NAK  = 8'h15;

  // Width of a payload index; never narrower than one bit.
  function automatic int idx_width(input int max_len);
    return (max_len <= 1) ? 1 : $clog2(max_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
// ============================================================================
// Module   : uart_cmd_timeout
// Summary  : Inter-byte idle counter; pulses expired_o when it reaches
//            TIMEOUT_CYCLES while enabled and not being cleared.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  C_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != C_LIMIT) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner leaves its active states on expiry, which clears the count.
  assign expired_o = enable_i && !clear_i && (cnt_q == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// Module   : uart_cmd_parser
// Summary  : Assembles checksummed command frames from UART bytes, strobes
//            good commands out and answers every frame with ACK or NAK.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = C_DEF_SYNC,
  parameter logic [7:0] ACK_BYTE       = C_DEF_ACK,
  parameter logic [7:0] NAK_BYTE       = C_DEF_NAK,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_err_i,
  input  logic                 tx_busy_i,
  output logic                 tx_start_o,
  output logic [7:0]           tx_data_o,
  output logic                 cmd_valid_o,
  output logic [7:0]           cmd_id_o,
  output logic [3:0]           cmd_len_o,
  output logic [8*MAX_LEN-1:0] cmd_payload_o,
  output logic [7:0]           err_count_o
);

  localparam int              IDX_W     = idx_width(MAX_LEN);
  localparam logic [7:0]      C_MAX_LEN = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] C_IDX_ONE = IDX_W'(1);

  state_e               state_q;
  logic [7:0]           id_q;
  logic [7:0]           sum_q;
  logic [7:0]           resp_q;
  logic [3:0]           len_q;
  logic [IDX_W-1:0]     idx_q;
  logic [7:0]           buf_q [MAX_LEN];

  logic                 tx_start_q;
  logic [7:0]           tx_data_q;
  logic                 cmd_valid_q;
  logic [7:0]           cmd_id_q;
  logic [3:0]           cmd_len_q;
  logic [8*MAX_LEN-1:0] cmd_payload_q;
  logic [7:0]           err_count_q;

  logic                 w_active;
  logic                 w_expired;
  logic [7:0]           w_err_inc;
  logic                 w_idx_last;
  logic [8*MAX_LEN-1:0] w_payload;

  assign w_active = (state_q == S_ID) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (rx_valid_i || !w_active),
    .enable_i  (w_active),
    .expired_o (w_expired)
  );

  assign w_err_inc  = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
  assign w_idx_last = ((4'(idx_q) + 4'd1) == len_q);

  // Bytes beyond the frame length are forced to zero on the way out.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    localparam logic [3:0] C_POS = 4'(gi);
    assign w_payload[8*gi +: 8] = (C_POS < len_q) ? buf_q[gi] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_SYNC;
      id_q          <= 8'h00;
      sum_q         <= 8'h00;
      resp_q        <= 8'h00;
      len_q         <= 4'h0;
      idx_q         <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= 8'h00;
      end
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      cmd_valid_q   <= 1'b0;
      cmd_id_q      <= 8'h00;
      cmd_len_q     <= 4'h0;
      cmd_payload_q <= '0;
      err_count_q   <= 8'h00;
    end else begin
      tx_start_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      if (w_active && (rx_err_i || w_expired)) begin
        state_q     <= S_SYNC;
        err_count_q <= w_err_inc;
      end else begin
        case (state_q)
          S_SYNC: begin
            if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
              state_q <= S_ID;
            end
          end
          S_ID: begin
            if (rx_valid_i) begin
              id_q    <= rx_data_i;
              sum_q   <= rx_data_i;
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (rx_valid_i) begin
              sum_q <= sum_q + rx_data_i;
              len_q <= rx_data_i[3:0];
              idx_q <= '0;
              if (rx_data_i > C_MAX_LEN) begin
                resp_q      <= NAK_BYTE;
                err_count_q <= w_err_inc;
                state_q     <= S_RESP;
              end else if (rx_data_i == 8'h00) begin
                state_q <= S_CHK;
              end else begin
                state_q <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (rx_valid_i) begin
              buf_q[idx_q] <= rx_data_i;
              sum_q        <= sum_q + rx_data_i;
              idx_q        <= idx_q + C_IDX_ONE;
              if (w_idx_last) begin
                state_q <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (rx_valid_i) begin
              if (rx_data_i == sum_q) begin
                cmd_id_q      <= id_q;
                cmd_len_q     <= len_q;
                cmd_payload_q <= w_payload;
                cmd_valid_q   <= 1'b1;
                resp_q        <= ACK_BYTE;
              end else begin
                resp_q      <= NAK_BYTE;
                err_count_q <= w_err_inc;
              end
              state_q <= S_RESP;
            end
          end
          S_RESP: begin
            // Incoming bytes are dropped here; one start per visit.
            if (!tx_busy_i) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= resp_q;
              state_q    <= S_SYNC;
            end
          end
          default: state_q <= S_SYNC;
        endcase
      end
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_id_o      = cmd_id_q;
  assign cmd_len_o     = cmd_len_q;
  assign cmd_payload_o = cmd_payload_q;
  assign err_count_o   = err_count_q;

endmodule

`default_nettype wire
